// File: rtl/mul4_score_pkg.sv
// -----------------------------------------------------------------------------
// mul4_score_pkg
// Shared types and helpers for the mul4 fitness scorer.
//   LANE_W / NUM_LANES : geometry of one mul4 output vector (4 x 16 bits)
//   lane_t / lanes_t   : one lane / all four lanes packed lane3..lane0
//   state_t            : scorer batch state (ACCUM, DRAIN, RESULT)
//   xor_lanes()        : bitwise difference of candidate and golden vectors
// -----------------------------------------------------------------------------
package mul4_score_pkg;

  localparam int LANE_W    = 16;
  localparam int NUM_LANES = 4;

  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t [NUM_LANES-1:0] lanes_t;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    RESULT = 2'd2
  } state_t;

  // A set bit marks a wrong output bit in the candidate vector.
  function automatic lanes_t xor_lanes(input lanes_t i_cand, input lanes_t i_gold);
    return i_cand ^ i_gold;
  endfunction

endpackage

// File: rtl/mul4_fitness_scorer_popcount16.sv
// -----------------------------------------------------------------------------
// popcount16
// Combinational population count of one 16-bit lane.
//   i_data  [15:0] : lane difference bits
//   o_count [4:0]  : number of set bits (0..16)
// -----------------------------------------------------------------------------
module popcount16 (
  input  logic [15:0] i_data,
  output logic [4:0]  o_count
);

  // Sum the individual bits of the lane.
  always_comb begin
    o_count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      o_count = o_count + {4'd0, i_data[i]};
    end
  end

endmodule

// File: rtl/mul4_fitness_scorer.sv
// -----------------------------------------------------------------------------
// mul4_fitness_scorer
// Scores one batch of mul4 output beats against golden products and returns a
// single fitness record (total mismatched bits) per batch.
//
// Ports:
//   clk, rst (async, active high)
//   in_valid / in_ready / in_last   : beat handshake, in_last closes a batch
//   y3..y0, e3..e0 [15:0]           : candidate and expected lane outputs
//   score_valid / score_ready       : record handshake
//   score [ACC_W-1:0]               : mismatched bits in the batch (saturating)
//   n_vectors [CNT_W-1:0]           : beats in the batch (1..MAX_VECTORS)
//   perfect                         : score == 0
//   overflow                        : batch cut at MAX_VECTORS without in_last
//   lane_score                      : per-lane totals, lane3..lane0
//                                     (only with MUL4_LANE_SCORE_EN defined)
//
// Pipeline: S1 holds the 64-bit difference, S2 holds its popcount; a beat
// accepted at edge T lands in the accumulator at T+2 and the record appears
// at T+3 for the closing beat.
// -----------------------------------------------------------------------------
module mul4_fitness_scorer
  import mul4_score_pkg::*;
#(
  parameter int MAX_VECTORS = 256,
  parameter int ACC_W       = $clog2(MAX_VECTORS*64+1),
  parameter int CNT_W       = $clog2(MAX_VECTORS+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [15:0]      y3,
  input  logic [15:0]      y2,
  input  logic [15:0]      y1,
  input  logic [15:0]      y0,
  input  logic [15:0]      e3,
  input  logic [15:0]      e2,
  input  logic [15:0]      e1,
  input  logic [15:0]      e0,
  output logic             score_valid,
  input  logic             score_ready,
  output logic [ACC_W-1:0] score,
  output logic [CNT_W-1:0] n_vectors,
  output logic             perfect,
  output logic             overflow
`ifdef MUL4_LANE_SCORE_EN
  ,
  output logic [NUM_LANES*(ACC_W-2)-1:0] lane_score
`endif
);

  // One lane carries at most a quarter of the total, so two bits fewer suffice.
  localparam int LACC_W = ACC_W - 2;

  state_t           r_state;
  lanes_t           r_s1_xor;
  logic             r_s1_valid;
  logic [6:0]       r_s2_pop;
  logic             r_s2_valid;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_accept;
  lanes_t           w_xor;
  logic [4:0]       w_lane_pop [NUM_LANES];
  logic [6:0]       w_pop_sum;
  logic [ACC_W:0]   w_acc_sum;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_hit_max;

  assign w_accept   = in_valid && in_ready;
  assign w_xor      = xor_lanes({y3, y2, y1, y0}, {e3, e2, e1, e0});
  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_hit_max  = (w_cnt_next == CNT_W'(MAX_VECTORS));
  assign w_acc_sum  = {1'b0, r_acc} + {{(ACC_W-6){1'b0}}, r_s2_pop};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_pc
    popcount16 u_pc (
      .i_data  (r_s1_xor[g]),
      .o_count (w_lane_pop[g])
    );
  end

  // Combine the four lane counts into the 0..64 beat count.
  always_comb begin
    w_pop_sum = 7'd0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_pop_sum = w_pop_sum + {2'd0, w_lane_pop[i]};
    end
  end

  // Saturate the total instead of wrapping on narrow accumulator widths.
  always_comb begin
    if (w_acc_sum[ACC_W]) begin
      w_acc_next = {ACC_W{1'b1}};
    end else begin
      w_acc_next = w_acc_sum[ACC_W-1:0];
    end
  end

`ifdef MUL4_LANE_SCORE_EN
  logic [4:0]        r_s2_lane_pop [NUM_LANES];
  logic [LACC_W-1:0] r_lane_acc    [NUM_LANES];
  logic [LACC_W-1:0] w_lane_next   [NUM_LANES];
  logic [LACC_W:0]   w_lane_sum    [NUM_LANES];

  // Per-lane saturating totals, mirroring the main accumulator.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      w_lane_sum[i] = {1'b0, r_lane_acc[i]} + {{(LACC_W-4){1'b0}}, r_s2_lane_pop[i]};
      if (w_lane_sum[i][LACC_W]) begin
        w_lane_next[i] = {LACC_W{1'b1}};
      end else begin
        w_lane_next[i] = w_lane_sum[i][LACC_W-1:0];
      end
    end
  end
`endif

  // Two-stage difference/popcount pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_xor   <= '0;
      r_s1_valid <= 1'b0;
      r_s2_pop   <= 7'd0;
      r_s2_valid <= 1'b0;
`ifdef MUL4_LANE_SCORE_EN
      for (int i = 0; i < NUM_LANES; i++) r_s2_lane_pop[i] <= 5'd0;
`endif
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) r_s1_xor <= w_xor;
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_pop <= w_pop_sum;
`ifdef MUL4_LANE_SCORE_EN
        for (int i = 0; i < NUM_LANES; i++) r_s2_lane_pop[i] <= w_lane_pop[i];
`endif
      end
    end
  end

  // Batch FSM: accumulation, beat counting and the registered fitness record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      in_ready    <= 1'b1;
      score_valid <= 1'b0;
      score       <= '0;
      n_vectors   <= '0;
      perfect     <= 1'b0;
      overflow    <= 1'b0;
`ifdef MUL4_LANE_SCORE_EN
      for (int i = 0; i < NUM_LANES; i++) r_lane_acc[i] <= '0;
      lane_score <= '0;
`endif
    end else begin
      // S2 never holds data in RESULT, so the clear below cannot collide.
      if (r_s2_valid) begin
        r_acc <= w_acc_next;
`ifdef MUL4_LANE_SCORE_EN
        for (int i = 0; i < NUM_LANES; i++) r_lane_acc[i] <= w_lane_next[i];
`endif
      end
      case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_cnt <= w_cnt_next;
            if (in_last || w_hit_max) begin
              r_state  <= DRAIN;
              in_ready <= 1'b0;
              r_ovf    <= !in_last;
            end
          end
        end
        DRAIN: begin
          if (!r_s1_valid && !r_s2_valid) begin
            r_state     <= RESULT;
            score_valid <= 1'b1;
            score       <= r_acc;
            n_vectors   <= r_cnt;
            perfect     <= (r_acc == '0);
            overflow    <= r_ovf;
`ifdef MUL4_LANE_SCORE_EN
            for (int i = 0; i < NUM_LANES; i++) lane_score[i*LACC_W +: LACC_W] <= r_lane_acc[i];
`endif
          end
        end
        RESULT: begin
          if (score_ready) begin
            r_state     <= ACCUM;
            in_ready    <= 1'b1;
            score_valid <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            score       <= '0;
            n_vectors   <= '0;
            perfect     <= 1'b0;
            overflow    <= 1'b0;
`ifdef MUL4_LANE_SCORE_EN
            for (int i = 0; i < NUM_LANES; i++) r_lane_acc[i] <= '0;
            lane_score <= '0;
`endif
          end
        end
        default: begin
          r_state     <= ACCUM;
          in_ready    <= 1'b1;
          score_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
